// File: rtl/gnr_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module : gnr_ctrl_pkg
// Desc   : Shared state encoding, sub-phase codes and defaults for the GRN
//          Floyd cycle-detection sequencer.
// Rev    : 1.0  initial release
// ============================================================================
package gnr_ctrl_pkg;

    localparam int c_default_max_iter = 1024;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_P1      = 3'd2,
        ST_P2      = 3'd3,
        ST_P3_LOAD = 3'd4,
        ST_P3_ADV  = 3'd5,
        ST_P3_MU   = 3'd6,
        ST_DONE    = 3'd7
    } gnr_state_e;

    // Cycle position inside one multi-cycle iteration of P1, P2 or P3_MU.
    typedef logic [1:0] gnr_sub_t;
    localparam gnr_sub_t c_sub_step1 = 2'd0;
    localparam gnr_sub_t c_sub_step2 = 2'd1;
    localparam gnr_sub_t c_sub_cmp   = 2'd2;

endpackage
`default_nettype wire

// File: rtl/gnr_state_cmp.sv
`default_nettype none
// ============================================================================
// Module : gnr_state_cmp
// Desc   : Equality comparator over the registered node s0/s1 outputs,
//          qualified so a match is only reported in compare cycles.
// Rev    : 1.0  initial release
// ============================================================================
module gnr_state_cmp #(
    parameter int WIDTH = 8
) (
    input  logic             i_sample,
    input  logic [WIDTH-1:0] i_s0_vec,
    input  logic [WIDTH-1:0] i_s1_vec,
    output logic             o_match
);

    assign o_match = i_sample && (i_s0_vec == i_s1_vec);

endmodule
`default_nettype wire

// File: rtl/gnr_floyd_ctrl.sv
`default_nettype none
// ============================================================================
// Module : gnr_floyd_ctrl
// Desc   : Sequences the GRN node array through Floyd cycle detection and
//          reports transient length (mu) and attractor period (lambda).
// Rev    : 1.0  initial release
// ============================================================================
module gnr_floyd_ctrl
    import gnr_ctrl_pkg::*;
#(
    parameter int N_NODES  = 8,
    parameter int MAX_ITER = c_default_max_iter,
    parameter int CNT_W    = $clog2(MAX_ITER + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [N_NODES-1:0] init_vec,
    input  logic [N_NODES-1:0] s0_vec,
    input  logic [N_NODES-1:0] s1_vec,
    output logic               reset_nos,
    output logic [N_NODES-1:0] init_state,
    output logic               start_s0,
    output logic               start_s1,
    output logic               busy,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [CNT_W-1:0]   transient_len,
    output logic [CNT_W-1:0]   period_len,
    output logic               timeout
);

    localparam logic [CNT_W-1:0] c_max_cnt = CNT_W'(MAX_ITER);
    localparam logic [CNT_W-1:0] c_one     = CNT_W'(1);

    gnr_state_e         r_state_q, w_state_d;
    gnr_sub_t           r_sub_q,   w_sub_d;
    logic [N_NODES-1:0] r_vec_q,   w_vec_d;
    logic [CNT_W-1:0]   r_it_q,    w_it_d;
    logic [CNT_W-1:0]   r_lam_q,   w_lam_d;
    logic [CNT_W-1:0]   r_mu_q,    w_mu_d;
    logic [CNT_W-1:0]   r_dn_q,    w_dn_d;
    logic [CNT_W-1:0]   r_tlen_q,  w_tlen_d;
    logic [CNT_W-1:0]   r_plen_q,  w_plen_d;
    logic               r_tout_q,  w_tout_d;
    logic               w_cmp_en;
    logic               w_match;

    gnr_state_cmp #(
        .WIDTH (N_NODES)
    ) u_cmp (
        .i_sample (w_cmp_en),
        .i_s0_vec (s0_vec),
        .i_s1_vec (s1_vec),
        .o_match  (w_match)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= ST_IDLE;
            r_sub_q   <= c_sub_step1;
            r_vec_q   <= '0;
            r_it_q    <= '0;
            r_lam_q   <= '0;
            r_mu_q    <= '0;
            r_dn_q    <= '0;
            r_tlen_q  <= '0;
            r_plen_q  <= '0;
            r_tout_q  <= 1'b0;
        end else begin
            r_state_q <= w_state_d;
            r_sub_q   <= w_sub_d;
            r_vec_q   <= w_vec_d;
            r_it_q    <= w_it_d;
            r_lam_q   <= w_lam_d;
            r_mu_q    <= w_mu_d;
            r_dn_q    <= w_dn_d;
            r_tlen_q  <= w_tlen_d;
            r_plen_q  <= w_plen_d;
            r_tout_q  <= w_tout_d;
        end
    end

    always_comb begin
        w_state_d = r_state_q;
        w_sub_d   = r_sub_q;
        w_vec_d   = r_vec_q;
        w_it_d    = r_it_q;
        w_lam_d   = r_lam_q;
        w_mu_d    = r_mu_q;
        w_dn_d    = r_dn_q;
        w_tlen_d  = r_tlen_q;
        w_plen_d  = r_plen_q;
        w_tout_d  = r_tout_q;
        unique case (r_state_q)
            ST_IDLE: begin
                if (start) begin
                    w_vec_d   = init_vec;
                    w_state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                w_it_d    = '0;
                w_lam_d   = '0;
                w_mu_d    = '0;
                w_tlen_d  = '0;
                w_plen_d  = '0;
                w_tout_d  = 1'b0;
                w_sub_d   = c_sub_step1;
                w_state_d = ST_P1;
            end
            ST_P1: begin
                if (r_sub_q == c_sub_step1) begin
                    w_sub_d = c_sub_step2;
                end else if (r_sub_q == c_sub_step2) begin
                    w_sub_d = c_sub_cmp;
                end else begin
                    w_it_d  = r_it_q + c_one;
                    w_sub_d = c_sub_step1;
                    if (w_match) begin
                        w_state_d = ST_P2;
                    end else if (w_it_d == c_max_cnt) begin
                        w_tout_d  = 1'b1;
                        w_state_d = ST_DONE;
                    end
                end
            end
            ST_P2: begin
                if (r_sub_q == c_sub_step1) begin
                    w_sub_d = c_sub_cmp;
                end else begin
                    w_lam_d = r_lam_q + c_one;
                    w_sub_d = c_sub_step1;
                    if (w_match) begin
                        w_state_d = ST_P3_LOAD;
                    end else if (w_lam_d == c_max_cnt) begin
                        w_tout_d  = 1'b1;
                        w_state_d = ST_DONE;
                    end
                end
            end
            ST_P3_LOAD: begin
                w_dn_d    = r_lam_q;
                w_state_d = ST_P3_ADV;
            end
            ST_P3_ADV: begin
                // Hare gets a head start of exactly lambda steps.
                w_dn_d = r_dn_q - c_one;
                if (r_dn_q == c_one) begin
                    w_sub_d   = c_sub_cmp;
                    w_state_d = ST_P3_MU;
                end
            end
            ST_P3_MU: begin
                if (r_sub_q == c_sub_step1) begin
                    w_sub_d = c_sub_step2;
                end else if (r_sub_q == c_sub_step2) begin
                    w_mu_d  = r_mu_q + c_one;
                    w_sub_d = c_sub_cmp;
                end else if (w_match) begin
                    w_tlen_d  = r_mu_q;
                    w_plen_d  = r_lam_q;
                    w_state_d = ST_DONE;
                end else begin
                    w_sub_d = c_sub_step1;
                end
            end
            ST_DONE: begin
                if (res_ready) begin
                    w_state_d = ST_IDLE;
                end
            end
            default: w_state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        reset_nos  = 1'b0;
        init_state = '0;
        start_s0   = 1'b0;
        start_s1   = 1'b0;
        res_valid  = 1'b0;
        w_cmp_en   = 1'b0;
        busy       = (r_state_q != ST_IDLE) && (r_state_q != ST_DONE);
        unique case (r_state_q)
            ST_LOAD, ST_P3_LOAD: begin
                reset_nos  = 1'b1;
                init_state = r_vec_q;
            end
            ST_P1: begin
                start_s0 = (r_sub_q != c_sub_cmp);
                start_s1 = (r_sub_q != c_sub_cmp);
                w_cmp_en = (r_sub_q == c_sub_cmp);
            end
            ST_P2: begin
                start_s1 = (r_sub_q == c_sub_step1);
                w_cmp_en = (r_sub_q != c_sub_step1);
            end
            ST_P3_ADV: start_s1 = 1'b1;
            ST_P3_MU: begin
                // Two s0 pulses per iteration move the tortoise one real step.
                start_s0 = (r_sub_q == c_sub_step1) || (r_sub_q == c_sub_step2);
                start_s1 = (r_sub_q == c_sub_step1);
                w_cmp_en = (r_sub_q == c_sub_cmp);
            end
            ST_DONE: res_valid = 1'b1;
            default: ;
        endcase
    end

    assign transient_len = r_tlen_q;
    assign period_len    = r_plen_q;
    assign timeout       = r_tout_q;

endmodule
`default_nettype wire
